// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port RAM between the core's fetch
// port and a program loader, with bounded loader bursts and address error checks.
module imem_arbiter #(
    parameter int          ADDR_W    = 9,
    parameter int          MAX_BURST = 4,
    parameter logic [31:0] ERR_WORD  = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              core_hold
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic             err_reg, err_next;
    logic             we_reg, we_next;

    // Misaligned or beyond the memory's byte range.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    logic f_bad, l_bad, fetch_turn;

    assign f_bad      = addr_bad(f_addr);
    assign l_bad      = addr_bad(l_addr);
    assign fetch_turn = f_req && (burst_cnt_reg == CNT_W'(MAX_BURST));

    // Grants are gated by reset so every output is quiet while reset is held.
    assign l_gnt = reset_n && l_req && !fetch_turn;
    assign f_gnt = reset_n && f_req && !l_gnt;

    always_comb begin
        state_next     = IDLE;
        burst_cnt_next = burst_cnt_reg;
        err_next       = 1'b0;
        we_next        = 1'b0;
        m_en           = 1'b0;
        m_we           = 1'b0;
        m_addr         = '0;
        m_wdata        = '0;

        if (l_gnt) begin
            state_next = LOAD;
            err_next   = l_bad;
            we_next    = l_we;
            m_en       = !l_bad;
            m_we       = l_we && !l_bad;
            m_addr     = l_addr[ADDR_W+1:2];
            m_wdata    = (l_we && !l_bad) ? l_wdata : 32'd0;
        end else if (f_gnt) begin
            state_next = FETCH;
            err_next   = f_bad;
            m_en       = !f_bad;
            m_addr     = f_addr[ADDR_W+1:2];
        end

        // Count loader grants that starve a waiting fetch.
        if (f_gnt || !l_req) begin
            burst_cnt_next = '0;
        end else if (l_gnt && f_req && (burst_cnt_reg != CNT_W'(MAX_BURST))) begin
            burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            err_reg       <= 1'b0;
            we_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            err_reg       <= err_next;
            we_reg        <= we_next;
        end
    end

    // The state doubles as the response tag: it names last cycle's winner.
    assign f_rvalid  = (state_reg == FETCH);
    assign l_rvalid  = (state_reg == LOAD);
    assign f_err     = f_rvalid && err_reg;
    assign l_err     = l_rvalid && err_reg;
    assign f_rdata   = !f_rvalid ? 32'd0 : (err_reg ? ERR_WORD : m_rdata);
    assign l_rdata   = (l_rvalid && !err_reg && !we_reg) ? m_rdata : 32'd0;
    assign core_hold = (state_reg == LOAD) || l_gnt;

endmodule
